// File: rtl/serial_byte_tx_if.sv
// Byte-load handshake and framed serial output of serial_byte_tx.
// master = byte producer (testbench/upstream), slave = the transmitter.
interface serial_byte_tx_if;
  logic [7:0] data_in;
  logic       load;
  logic       ready;
  logic       so;
  logic       busy;
  logic       done;

  modport master (output data_in, load, input ready, so, busy, done);
  modport slave  (input data_in, load, output ready, so, busy, done);
endinterface

// File: rtl/serial_byte_tx.sv
// Start/8-data/stop serial framer, LSB first, CLKS_PER_BIT clocks per bit.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module serial_byte_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic            clock,
  input  logic            reset,
  serial_byte_tx_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SERIAL_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  localparam logic [7:0] CNT_MAX = 8'(CLKS_PER_BIT - 1);

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [7:0] shift, shift_n;
  logic       bit_end;
`ifdef SERIAL_TX_PARITY_EN
  logic       par, par_n;
`endif

  assign bit_end = (cnt == CNT_MAX);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
`ifdef SERIAL_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
`ifdef SERIAL_TX_PARITY_EN
      par     <= par_n;
`endif
    end
  end

  // NOTE: every signal gets its hold value first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
`ifdef SERIAL_TX_PARITY_EN
    par_n     = par;
`endif
    if (state == IDLE) begin
      // ready is high exactly in IDLE, so a load here is an accepted load
      if (bus.load) begin
        shift_n   = bus.data_in;
        cnt_n     = '0;
        bit_idx_n = '0;
`ifdef SERIAL_TX_PARITY_EN
        par_n     = ^bus.data_in;
`endif
        state_n   = START;
      end
    end else begin
      cnt_n = bit_end ? 8'd0 : 8'(cnt + 8'd1);
      if (bit_end) begin
        case (state)
          START: state_n = DATA;
          DATA: begin
            shift_n   = shift >> 1;
            bit_idx_n = 3'(bit_idx + 3'd1);
            if (bit_idx == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end
          end
`ifdef SERIAL_TX_PARITY_EN
          PARITY: state_n = STOP;
`endif
          STOP:    state_n = IDLE;
          default: state_n = IDLE;
        endcase
      end
    end
  end

  // Outputs decode registered state only; load/data_in never reach them.
  always_comb begin
    bus.so    = 1'b1;
    bus.ready = (state == IDLE);
    bus.busy  = (state != IDLE);
    bus.done  = (state == STOP) && bit_end;
    case (state)
      START:   bus.so = 1'b0;
      DATA:    bus.so = shift[0];
`ifdef SERIAL_TX_PARITY_EN
      PARITY:  bus.so = par;
`endif
      default: bus.so = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_serial_byte_tx.sv
// Scoreboard bench for serial_byte_tx: two instances (CLKS_PER_BIT 4 and 1),
// expected per-cycle so/done values queued at load time and popped each cycle.
module tb_serial_byte_tx;

`ifdef SERIAL_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  typedef struct packed {
    logic so;
    logic done;
  } exp_t;

  logic clock;
  logic reset;
  bit   sel1;
  int   n_checks;
  int   n_fail;
  exp_t exp_q[$];

  serial_byte_tx_if bus4 ();
  serial_byte_tx_if bus1 ();

  serial_byte_tx #(.CLKS_PER_BIT(4)) dut4 (.clock(clock), .reset(reset), .bus(bus4.slave));
  serial_byte_tx #(.CLKS_PER_BIT(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1.slave));

  logic m_so, m_ready, m_busy, m_done;
  assign m_so    = sel1 ? bus1.so    : bus4.so;
  assign m_ready = sel1 ? bus1.ready : bus4.ready;
  assign m_busy  = sel1 ? bus1.busy  : bus4.busy;
  assign m_done  = sel1 ? bus1.done  : bus4.done;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int cpb();
    return sel1 ? 1 : 4;
  endfunction

  task automatic drive(input logic l, input logic [7:0] d);
    if (sel1) begin
      bus1.load = l; bus1.data_in = d;
    end else begin
      bus4.load = l; bus4.data_in = d;
    end
  endtask

  task automatic cmp(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
    end
  endtask

  // Expected frame: start, d0..d7, [even parity], stop; each bit cpb() cycles.
  task automatic push_frame(input logic [7:0] d);
    logic v;
    for (int b = 0; b < NBITS; b++) begin
      if (b == 0)               v = 1'b0;
      else if (b <= 8)          v = d[b-1];
      else if (b == NBITS - 1)  v = 1'b1;
      else                      v = ^d;
      for (int k = 0; k < cpb(); k++)
        exp_q.push_back('{so: v, done: (b == NBITS - 1) && (k == cpb() - 1)});
    end
  endtask

  task automatic check_cycle(input string name);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s scoreboard empty at %0t: got so=%b, expected no frame cycle", name, $time, m_so);
    end else begin
      e = exp_q.pop_front();
      cmp({name, " so"},    m_so,    e.so);
      cmp({name, " done"},  m_done,  e.done);
      cmp({name, " busy"},  m_busy,  1'b1);
      cmp({name, " ready"}, m_ready, 1'b0);
    end
  endtask

  task automatic check_idle(input string name, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clock);
      cmp({name, " so"},    m_so,    1'b1);
      cmp({name, " ready"}, m_ready, 1'b1);
      cmp({name, " busy"},  m_busy,  1'b0);
      cmp({name, " done"},  m_done,  1'b0);
    end
  endtask

  task automatic start_frame(input logic [7:0] d);
    @(negedge clock);
    drive(1'b1, d);
    push_frame(d);
    @(posedge clock);
  endtask

  // Checks ncyc frame cycles after an accept. keep_load holds load high with
  // hold_d; pulse_at >= 0 pulses a (to be ignored) load of pulse_d.
  task automatic check_frame(input string name, input int ncyc, input bit keep_load,
                             input logic [7:0] hold_d, input int pulse_at,
                             input logic [7:0] pulse_d);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clock);
      check_cycle(name);
      if (keep_load)          drive(1'b1, hold_d);
      else if (i == pulse_at) drive(1'b1, pulse_d);
      else                    drive(1'b0, pulse_d);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    check_idle("reset_held", 3);
    reset = 1'b0;
    check_idle("reset_idle", 20);
  endtask

  task automatic test_single();
    start_frame(8'hA5);
    check_frame("single_a5", NBITS * cpb(), 1'b0, 8'h00, -1, 8'h00);
    check_idle("single_after", 2);
  endtask

  task automatic test_back_to_back();
    start_frame(8'h01);
    check_frame("b2b_01", NBITS * cpb(), 1'b1, 8'hFF, -1, 8'h00);
    check_idle("b2b_gap", 1);
    push_frame(8'hFF);
    @(posedge clock);
    check_frame("b2b_ff", NBITS * cpb(), 1'b0, 8'h00, -1, 8'h00);
    check_idle("b2b_after", 2);
  endtask

  task automatic test_ignored_load();
    start_frame(8'h81);
    check_frame("ignored_81", NBITS * cpb(), 1'b0, 8'h00, 15, 8'h3C);
    check_idle("ignored_after", 3 * cpb());
  endtask

  task automatic test_reset_mid();
    start_frame(8'h5A);
    // first cycle of data bit 3 is frame cycle 4*cpb()+1
    check_frame("midrst_pre", 4 * cpb() + 1, 1'b0, 8'h00, -1, 8'h00);
    @(negedge clock);
    reset = 1'b1;
    #1;
    cmp("midrst_async so",    m_so,    1'b1);
    cmp("midrst_async busy",  m_busy,  1'b0);
    cmp("midrst_async ready", m_ready, 1'b1);
    cmp("midrst_async done",  m_done,  1'b0);
    exp_q.delete();
    check_idle("midrst_held", 2);
    reset = 1'b0;
    start_frame(8'h0F);
    check_frame("midrst_0f", NBITS * cpb(), 1'b0, 8'h00, -1, 8'h00);
    check_idle("midrst_after", 2);
  endtask

  task automatic test_cpb1();
    sel1 = 1'b1;
    check_idle("cpb1_idle", 2);
    start_frame(8'h80);
    check_frame("cpb1_80", NBITS, 1'b0, 8'h00, -1, 8'h00);
    check_idle("cpb1_after", 2);
    start_frame(8'h37);
    check_frame("cpb1_37", NBITS, 1'b0, 8'h00, -1, 8'h00);
    check_idle("cpb1_after2", 2);
    sel1 = 1'b0;
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    sel1         = 1'b0;
    reset        = 1'b1;
    bus4.load    = 1'b0;
    bus4.data_in = 8'h00;
    bus1.load    = 1'b0;
    bus1.data_in = 8'h00;

    test_reset();
    test_single();
    test_back_to_back();
    test_ignored_load();
    test_reset_mid();
    test_cpb1();

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
